// File: rtl/thor2023_pma_checker_pkg.sv
// Shared types for the physical-memory-attribute checker.
//   pma_cause_t : 3-bit fault cause reported with every response
//   pma_acc_t   : 2-bit access type carried with every request
//   RWX_*       : bit positions inside a region attribute rwx nibble
//   REGION_AT   : per-operating-mode attribute entry (rwx + dev_type)
//   REGION      : region record returned by the active-region selector
package thor2023_pma_checker_pkg;

   typedef enum logic [2:0] {
      PMA_NONE      = 3'd0,
      PMA_RGN_ERR   = 3'd1,
      PMA_NO_ACCESS = 3'd2,
      PMA_RD_VIOL   = 3'd3,
      PMA_WR_VIOL   = 3'd4,
      PMA_EX_VIOL   = 3'd5,
      PMA_BAD_ACC   = 3'd6
   } pma_cause_t;

   typedef enum logic [1:0] {
      PMA_ACC_RD  = 2'd0,
      PMA_ACC_WR  = 2'd1,
      PMA_ACC_EX  = 2'd2,
      PMA_ACC_RSV = 2'd3
   } pma_acc_t;

   localparam int unsigned RWX_C = 3;   // cacheable
   localparam int unsigned RWX_R = 2;   // readable
   localparam int unsigned RWX_W = 1;   // writable
   localparam int unsigned RWX_X = 0;   // executable

   // dev_type value marking a region that may not be touched at all
   localparam logic [7:0] DEV_NO_ACCESS = 8'hFF;

   typedef struct packed {
      logic [7:0] dev_type;
      logic [3:0] rwx;
   } REGION_AT;

   // One attribute entry per operating mode, indexed by om
   typedef struct packed {
      REGION_AT [3:0] at;
   } REGION;

endpackage

// File: rtl/thor2023_pma_perm.sv
// Combinational permission decode for one access against one attribute entry.
// Shared with the instruction-fetch path.
//   at         : attribute entry already selected for the operating mode
//   region_err : selector reported an error for this region
//   acc        : access type
//   cause      : highest-priority cause (RGN_ERR > NO_ACCESS > BAD_ACC > R/W/X)
//   fault      : cause != NONE
//   cacheable  : rwx cacheable bit, reported regardless of fault
module thor2023_pma_perm
   import thor2023_pma_checker_pkg::*;
(
   input  REGION_AT   at,
   input  logic       region_err,
   input  pma_acc_t   acc,
   output pma_cause_t cause,
   output logic       fault,
   output logic       cacheable
);

   always_comb begin
      cause = PMA_NONE;
      if (region_err) begin
         cause = PMA_RGN_ERR;
      end else if (at.dev_type == DEV_NO_ACCESS) begin
         cause = PMA_NO_ACCESS;
      end else begin
         case (acc)
            PMA_ACC_RD: if (!at.rwx[RWX_R]) cause = PMA_RD_VIOL;
            PMA_ACC_WR: if (!at.rwx[RWX_W]) cause = PMA_WR_VIOL;
            PMA_ACC_EX: if (!at.rwx[RWX_X]) cause = PMA_EX_VIOL;
            default:    cause = PMA_BAD_ACC;
         endcase
      end
   end

   assign fault     = (cause != PMA_NONE);
   assign cacheable = at.rwx[RWX_C];

endmodule

// File: rtl/thor2023_pma_checker.sv
// Two-stage physical-memory-attribute checker.
//   req_*     : request handshake; rgn drives the region selector directly
//               from req_adr, region/region_err return in the same cycle
//   rsp_*     : response handshake with cause, cacheability and dev_type
//   flt_*     : first unacknowledged fault, cleared by flt_clr; flt_count
//               is a saturating total cleared only by rst
// S1 holds the accepted request and the attribute entry sampled at accept,
// S2 is the output register. Accept in cycle N -> rsp_valid in cycle N+2.
module thor2023_pma_checker
   import thor2023_pma_checker_pkg::*;
#(
   parameter int unsigned ABITS   = 32,
   parameter int unsigned RGN_LSB = 29,
   parameter int unsigned TAGW    = 8,
   parameter int unsigned CNTW    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [ABITS-1:0] req_adr,
   input  logic [1:0]       req_om,
   input  logic [1:0]       req_acc,
   input  logic [TAGW-1:0]  req_tag,
   output logic [2:0]       rgn,
   input  REGION            region,
   input  logic             region_err,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [TAGW-1:0]  rsp_tag,
   output logic [ABITS-1:0] rsp_adr,
   output logic             rsp_fault,
   output pma_cause_t       rsp_cause,
   output logic             rsp_cacheable,
   output logic [7:0]       rsp_dev_type,
   output logic             flt_valid,
   output logic [ABITS-1:0] flt_adr,
   output pma_cause_t       flt_cause,
   input  logic             flt_clr,
   output logic [CNTW-1:0]  flt_count
);

   // S1 state
   logic             s1_valid_q, s1_valid_d;
   logic [ABITS-1:0] s1_adr_q, s1_adr_d;
   logic [TAGW-1:0]  s1_tag_q, s1_tag_d;
   REGION_AT         s1_at_q, s1_at_d;
   logic             s1_err_q, s1_err_d;
   pma_acc_t         s1_acc_q, s1_acc_d;

   // S2 (output) state
   logic             rsp_valid_q, rsp_valid_d;
   logic [ABITS-1:0] rsp_adr_q, rsp_adr_d;
   logic [TAGW-1:0]  rsp_tag_q, rsp_tag_d;
   logic             rsp_fault_q, rsp_fault_d;
   pma_cause_t       rsp_cause_q, rsp_cause_d;
   logic             rsp_cacheable_q, rsp_cacheable_d;
   logic [7:0]       rsp_dev_type_q, rsp_dev_type_d;

   // Fault capture state
   logic             flt_valid_q, flt_valid_d;
   logic [ABITS-1:0] flt_adr_q, flt_adr_d;
   pma_cause_t       flt_cause_q, flt_cause_d;
   logic [CNTW-1:0]  flt_count_q, flt_count_d;

   logic             s2_adv, s1_adv, req_fire, flt_beat;
   pma_cause_t       s1_cause;
   logic             s1_fault, s1_cacheable;

   assign rgn       = req_adr[RGN_LSB+2:RGN_LSB];
   assign s2_adv    = !rsp_valid_q || rsp_ready;
   assign s1_adv    = !s1_valid_q || s2_adv;
   assign req_ready = s1_adv;
   assign req_fire  = req_valid && s1_adv;

   // Stage S1: capture request and the om-selected attribute entry at accept
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_adr_d   = s1_adr_q;
      s1_tag_d   = s1_tag_q;
      s1_at_d    = s1_at_q;
      s1_err_d   = s1_err_q;
      s1_acc_d   = s1_acc_q;
      if (s1_adv) s1_valid_d = req_valid;
      if (req_fire) begin
         s1_adr_d = req_adr;
         s1_tag_d = req_tag;
         s1_at_d  = region.at[req_om];
         s1_err_d = region_err;
         s1_acc_d = pma_acc_t'(req_acc);
      end
   end

   thor2023_pma_perm u_perm (
      .at         (s1_at_q),
      .region_err (s1_err_q),
      .acc        (s1_acc_q),
      .cause      (s1_cause),
      .fault      (s1_fault),
      .cacheable  (s1_cacheable)
   );

   // Stage S2: output register, held while stalled
   always_comb begin
      rsp_valid_d     = rsp_valid_q;
      rsp_adr_d       = rsp_adr_q;
      rsp_tag_d       = rsp_tag_q;
      rsp_fault_d     = rsp_fault_q;
      rsp_cause_d     = rsp_cause_q;
      rsp_cacheable_d = rsp_cacheable_q;
      rsp_dev_type_d  = rsp_dev_type_q;
      if (s2_adv) rsp_valid_d = s1_valid_q;
      if (s2_adv && s1_valid_q) begin
         rsp_adr_d       = s1_adr_q;
         rsp_tag_d       = s1_tag_q;
         rsp_fault_d     = s1_fault;
         rsp_cause_d     = s1_cause;
         rsp_cacheable_d = s1_cacheable;
         rsp_dev_type_d  = s1_at_q.dev_type;
      end
   end

   // Fault capture on the delivered response beat; a new fault wins over clear
   always_comb begin
      flt_beat    = rsp_valid_q && rsp_ready && rsp_fault_q;
      flt_valid_d = flt_valid_q;
      flt_adr_d   = flt_adr_q;
      flt_cause_d = flt_cause_q;
      flt_count_d = flt_count_q;
      if (flt_beat && (flt_count_q != {CNTW{1'b1}})) flt_count_d = flt_count_q + 1'b1;
      if (flt_beat && (!flt_valid_q || flt_clr)) begin
         flt_valid_d = 1'b1;
         flt_adr_d   = rsp_adr_q;
         flt_cause_d = rsp_cause_q;
      end else if (flt_clr) begin
         flt_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q      <= 1'b0;
         s1_adr_q        <= '0;
         s1_tag_q        <= '0;
         s1_at_q         <= '0;
         s1_err_q        <= 1'b0;
         s1_acc_q        <= PMA_ACC_RD;
         rsp_valid_q     <= 1'b0;
         rsp_adr_q       <= '0;
         rsp_tag_q       <= '0;
         rsp_fault_q     <= 1'b0;
         rsp_cause_q     <= PMA_NONE;
         rsp_cacheable_q <= 1'b0;
         rsp_dev_type_q  <= '0;
         flt_valid_q     <= 1'b0;
         flt_adr_q       <= '0;
         flt_cause_q     <= PMA_NONE;
         flt_count_q     <= '0;
      end else begin
         s1_valid_q      <= s1_valid_d;
         s1_adr_q        <= s1_adr_d;
         s1_tag_q        <= s1_tag_d;
         s1_at_q         <= s1_at_d;
         s1_err_q        <= s1_err_d;
         s1_acc_q        <= s1_acc_d;
         rsp_valid_q     <= rsp_valid_d;
         rsp_adr_q       <= rsp_adr_d;
         rsp_tag_q       <= rsp_tag_d;
         rsp_fault_q     <= rsp_fault_d;
         rsp_cause_q     <= rsp_cause_d;
         rsp_cacheable_q <= rsp_cacheable_d;
         rsp_dev_type_q  <= rsp_dev_type_d;
         flt_valid_q     <= flt_valid_d;
         flt_adr_q       <= flt_adr_d;
         flt_cause_q     <= flt_cause_d;
         flt_count_q     <= flt_count_d;
      end
   end

   assign rsp_valid     = rsp_valid_q;
   assign rsp_tag       = rsp_tag_q;
   assign rsp_adr       = rsp_adr_q;
   assign rsp_fault     = rsp_fault_q;
   assign rsp_cause     = rsp_cause_q;
   assign rsp_cacheable = rsp_cacheable_q;
   assign rsp_dev_type  = rsp_dev_type_q;
   assign flt_valid     = flt_valid_q;
   assign flt_adr       = flt_adr_q;
   assign flt_cause     = flt_cause_q;
   assign flt_count     = flt_count_q;

endmodule

// File: tb/tb_thor2023_pma_checker.sv
// Testbench for thor2023_pma_checker: directed scenarios followed by a
// randomized run, all responses scored against a queue-based reference model.
`timescale 1ns/1ps
module tb_thor2023_pma_checker;
   import thor2023_pma_checker_pkg::*;

   localparam int ABITS   = 32;
   localparam int RGN_LSB = 29;
   localparam int TAGW    = 8;
   localparam int CNTW    = 4;
   localparam logic [CNTW-1:0] CNT_MAX = '1;

   logic             clk = 1'b0;
   logic             rst;
   logic             req_valid, req_ready;
   logic [ABITS-1:0] req_adr;
   logic [1:0]       req_om, req_acc;
   logic [TAGW-1:0]  req_tag;
   logic [2:0]       rgn;
   REGION            region;
   logic             region_err;
   logic             rsp_valid, rsp_ready;
   logic [TAGW-1:0]  rsp_tag;
   logic [ABITS-1:0] rsp_adr;
   logic             rsp_fault, rsp_cacheable;
   pma_cause_t       rsp_cause, flt_cause;
   logic [7:0]       rsp_dev_type;
   logic             flt_valid, flt_clr;
   logic [ABITS-1:0] flt_adr;
   logic [CNTW-1:0]  flt_count;

   always #5 clk = ~clk;

   // Behavioural region selector
   REGION tbl [8];
   logic  err_tbl [8];
   assign region     = tbl[rgn];
   assign region_err = err_tbl[rgn];

   thor2023_pma_checker #(.ABITS(ABITS), .RGN_LSB(RGN_LSB), .TAGW(TAGW), .CNTW(CNTW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_adr(req_adr),
      .req_om(req_om), .req_acc(req_acc), .req_tag(req_tag),
      .rgn(rgn), .region(region), .region_err(region_err),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
      .rsp_adr(rsp_adr), .rsp_fault(rsp_fault), .rsp_cause(rsp_cause),
      .rsp_cacheable(rsp_cacheable), .rsp_dev_type(rsp_dev_type),
      .flt_valid(flt_valid), .flt_adr(flt_adr), .flt_cause(flt_cause),
      .flt_clr(flt_clr), .flt_count(flt_count)
   );

   typedef struct {
      logic [TAGW-1:0]  tag;
      logic [ABITS-1:0] adr;
      logic [2:0]       cause;
      logic             cacheable;
      logic [7:0]       dev;
      int               cyc;
   } exp_t;

   exp_t             q[$];
   logic             m_flt_valid;
   logic [ABITS-1:0] m_flt_adr;
   logic [2:0]       m_flt_cause;
   int               m_flt_count;
   int               cyc;
   bit               lat_chk;
   bit               last_acc;
   int               n_checks = 0;
   int               n_errs   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference rule: error, then no-access device, then reserved access,
   // then the permission bit the access type needs (r for 0, w for 1, x for 2).
   function automatic logic [2:0] ref_cause(REGION_AT a, logic err, logic [1:0] acc);
      logic [3:0] need;
      if (err) return 3'd1;
      if (a.dev_type == 8'hFF) return 3'd2;
      if (acc == 2'd3) return 3'd6;
      need = 4'b0100 >> acc;
      if ((a.rwx & need) == 4'b0000) return 3'd3 + {1'b0, acc};
      return 3'd0;
   endfunction

   function automatic logic [63:0] pack_rsp();
      return 64'({rsp_tag, rsp_adr, rsp_fault, rsp_cause, rsp_cacheable, rsp_dev_type});
   endfunction

   // One clock: observe handshakes before the edge, check state after it.
   task automatic step();
      bit          acc_fire, rsp_fire, stalled, was_rst;
      logic [63:0] snap;
      exp_t        e, n;
      REGION_AT    a;
      logic [2:0]  r;
      #1;
      was_rst  = rst;
      acc_fire = req_valid && req_ready && !rst;
      rsp_fire = rsp_valid && rsp_ready && !rst;
      stalled  = rsp_valid && !rsp_ready && !rst;
      snap     = pack_rsp();
      check_eq("rgn", 64'(rgn), 64'((req_adr >> RGN_LSB) & 32'd7));
      if (rsp_fire) begin
         if (q.size() == 0) begin
            check_eq("rsp_spurious", 64'd1, 64'd0);
         end else begin
            e = q.pop_front();
            check_eq("rsp_tag", 64'(rsp_tag), 64'(e.tag));
            check_eq("rsp_adr", 64'(rsp_adr), 64'(e.adr));
            check_eq("rsp_cause", 64'(rsp_cause), 64'(e.cause));
            check_eq("rsp_fault", 64'(rsp_fault), 64'(e.cause != 3'd0));
            check_eq("rsp_cacheable", 64'(rsp_cacheable), 64'(e.cacheable));
            check_eq("rsp_dev_type", 64'(rsp_dev_type), 64'(e.dev));
            if (lat_chk) check_eq("latency", 64'(cyc - e.cyc), 64'd2);
            if (e.cause != 3'd0) begin
               if (m_flt_count < int'(CNT_MAX)) m_flt_count++;
               if (!m_flt_valid || flt_clr) begin
                  m_flt_valid = 1'b1;
                  m_flt_adr   = e.adr;
                  m_flt_cause = e.cause;
               end
            end else if (flt_clr) begin
               m_flt_valid = 1'b0;
            end
         end
      end else if (flt_clr && !rst) begin
         m_flt_valid = 1'b0;
      end
      if (acc_fire) begin
         r           = req_adr[RGN_LSB +: 3];
         a           = tbl[r].at[req_om];
         n.tag       = req_tag;
         n.adr       = req_adr;
         n.cause     = ref_cause(a, err_tbl[r], req_acc);
         n.cacheable = a.rwx[3];
         n.dev       = a.dev_type;
         n.cyc       = cyc;
         q.push_back(n);
      end
      last_acc = acc_fire;
      @(posedge clk);
      #1;
      cyc++;
      if (was_rst) begin
         q.delete();
         m_flt_valid = 1'b0;
         m_flt_adr   = '0;
         m_flt_cause = 3'd0;
         m_flt_count = 0;
      end
      check_eq("flt_valid", 64'(flt_valid), 64'(m_flt_valid));
      check_eq("flt_count", 64'(flt_count), 64'(m_flt_count));
      check_eq("flt_adr", 64'(flt_adr), 64'(m_flt_adr));
      check_eq("flt_cause", 64'(flt_cause), 64'(m_flt_cause));
      if (stalled && !rst) begin
         check_eq("hold_valid", 64'(rsp_valid), 64'd1);
         check_eq("hold_data", pack_rsp(), snap);
      end
      @(negedge clk);
   endtask

   task automatic send(input logic [31:0] adr, input logic [1:0] om,
                       input logic [1:0] acc, input logic [7:0] tag);
      int n = 0;
      req_valid = 1'b1;
      req_adr   = adr;
      req_om    = om;
      req_acc   = acc;
      req_tag   = tag;
      do begin
         step();
         n++;
      end while (!last_acc && n < 50);
      if (!last_acc) check_eq("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      repeat (n) step();
   endtask

   task automatic rand_entry(input logic [2:0] r, input logic [1:0] o);
      tbl[r].at[o].dev_type = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      tbl[r].at[o].rwx      = 4'($urandom);
      err_tbl[r]            = ($urandom_range(0, 11) == 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      int          accepts;
      logic [7:0]  t;
      int          guard;
      rst = 1'b1; req_valid = 1'b0; req_adr = '0; req_om = '0; req_acc = '0;
      req_tag = '0; rsp_ready = 1'b1; flt_clr = 1'b0;
      cyc = 0; lat_chk = 1'b0; last_acc = 1'b0;
      m_flt_valid = 1'b0; m_flt_adr = '0; m_flt_cause = 3'd0; m_flt_count = 0;
      for (int i = 0; i < 8; i++) begin
         tbl[i]     = '0;
         err_tbl[i] = 1'b0;
      end
      tbl[1].at[0] = '{dev_type: 8'h01, rwx: 4'hF};
      for (int i = 0; i < 4; i++) tbl[7].at[i] = '{dev_type: 8'h02, rwx: 4'hD};
      tbl[0].at[0] = '{dev_type: 8'hFF, rwx: 4'hF};
      err_tbl[0]   = 1'b1;

      @(negedge clk);
      step();
      step();
      rst = 1'b0;
      check_eq("rst_req_ready", 64'(req_ready), 64'd1);
      check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check_eq("rst_rsp_fault", 64'(rsp_fault), 64'd0);
      check_eq("rst_rsp_cause", 64'(rsp_cause), 64'd0);
      check_eq("rst_flt_cause", 64'(flt_cause), 64'd0);
      check_eq("rst_flt_count", 64'(flt_count), 64'd0);

      // DRAM write, then ROM write / execute, then error region
      lat_chk = 1'b1;
      send(32'h2000_0040, 2'd0, 2'd1, 8'h11);
      idle(3);
      send(32'hE000_0000, 2'd0, 2'd1, 8'h21);
      idle(3);
      check_eq("rom_wr_flt_valid", 64'(flt_valid), 64'd1);
      check_eq("rom_wr_flt_adr", 64'(flt_adr), 64'hE000_0000);
      check_eq("rom_wr_flt_cause", 64'(flt_cause), 64'd4);
      check_eq("rom_wr_flt_count", 64'(flt_count), 64'd1);
      send(32'hE000_0000, 2'd0, 2'd2, 8'h22);
      idle(3);
      check_eq("rom_ex_flt_count", 64'(flt_count), 64'd1);
      flt_clr = 1'b1; idle(1); flt_clr = 1'b0;
      check_eq("clr_flt_valid", 64'(flt_valid), 64'd0);
      check_eq("clr_flt_adr_held", 64'(flt_adr), 64'hE000_0000);
      send(32'h0000_0100, 2'd0, 2'd0, 8'h31);
      idle(3);
      check_eq("rgn_err_cause", 64'(flt_cause), 64'd1);
      flt_clr = 1'b1; idle(1); flt_clr = 1'b0;

      // Three back-to-back faults keep the first, then clear meets a new fault
      send(32'hE000_0010, 2'd0, 2'd1, 8'h41);
      send(32'hE000_0020, 2'd0, 2'd1, 8'h42);
      send(32'hE000_0030, 2'd0, 2'd1, 8'h43);
      idle(3);
      check_eq("b2b_flt_adr", 64'(flt_adr), 64'hE000_0010);
      check_eq("b2b_flt_count", 64'(flt_count), 64'd5);
      send(32'hE000_0040, 2'd0, 2'd1, 8'h44);
      idle(1);
      flt_clr = 1'b1; idle(1); flt_clr = 1'b0;
      check_eq("clr_vs_new_valid", 64'(flt_valid), 64'd1);
      check_eq("clr_vs_new_adr", 64'(flt_adr), 64'hE000_0040);
      check_eq("clr_vs_new_count", 64'(flt_count), 64'd6);
      idle(2);

      // Backpressure with a continuous request stream
      lat_chk   = 1'b0;
      rsp_ready = 1'b0;
      accepts   = 0;
      t         = 8'h50;
      req_valid = 1'b1; req_om = 2'd0; req_acc = 2'd0;
      for (int i = 0; i < 5; i++) begin
         req_tag = t;
         req_adr = 32'h2000_0000 + 32'(t);
         step();
         if (last_acc) begin accepts++; t++; end
      end
      check_eq("bp_accepts", 64'(accepts), 64'd2);
      check_eq("bp_req_ready_low", 64'(req_ready), 64'd0);
      rsp_ready = 1'b1;
      guard = 0;
      while (t != 8'h58 && guard < 40) begin
         req_tag = t;
         req_adr = 32'h2000_0000 + 32'(t);
         step();
         if (last_acc) t++;
         guard++;
      end
      idle(4);
      check_eq("bp_drained", 64'(q.size()), 64'd0);

      // Reset with two requests in flight
      rsp_ready = 1'b0;
      send(32'h2000_0000, 2'd0, 2'd0, 8'h60);
      send(32'h2000_0004, 2'd0, 2'd0, 8'h61);
      req_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_eq("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
      check_eq("midrst_flt_count", 64'(flt_count), 64'd0);
      check_eq("midrst_req_ready", 64'(req_ready), 64'd1);
      rsp_ready = 1'b1;
      idle(5);

      // Randomized traffic with table churn, backpressure and clears
      for (int r = 0; r < 8; r++)
         for (int o = 0; o < 4; o++) rand_entry(3'(r), 2'(o));
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) rand_entry(3'($urandom), 2'($urandom));
         req_valid = ($urandom_range(0, 3) != 0);
         req_adr   = $urandom;
         req_om    = 2'($urandom);
         req_acc   = 2'($urandom);
         req_tag   = 8'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         flt_clr   = ($urandom_range(0, 9) == 0);
         step();
      end
      flt_clr   = 1'b0;
      rsp_ready = 1'b1;
      idle(5);
      check_eq("final_drain", 64'(q.size()), 64'd0);
      check_eq("flt_count_saturated", 64'(flt_count), 64'(CNT_MAX));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
